rr_req_queue_mux: RTL and testbench

- Requester-side counterpart to the team's round-robin arbiter.
- Buffers payloads from NUM_REQS independent producers in per-channel FIFOs and drives one request line per non-empty channel into the arbiter.
- Consumes the arbiter's registered one-hot grants, pops the granted channel and forwards its payload, tagged with the channel id, onto a single shared output bus.
- Sits between producer ports (e.g. per-PE command sources) and a shared consumer (memory/NoC port).

---
 rtl/rr_arb_pkg.sv | 26 ++
 rtl/rr_chan_fifo.sv | 62 ++++++
 rtl/rr_req_queue_mux.sv | 94 +++++++++
 tb/tb_rr_req_queue_mux.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared constants and grant-vector helpers for the round-robin request queue mux
// and its companion arbiter.
package rr_arb_pkg;

  localparam int DEF_NUM_REQS = 4;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_DEPTH    = 4;
  localparam int MAX_REQS     = 64;
  localparam int MAX_ID_W     = 6;

  // Index of the set bit; only meaningful when the vector is one-hot.
  function automatic logic [MAX_ID_W-1:0] onehot_to_idx(input logic [MAX_REQS-1:0] vec);
    logic [MAX_ID_W-1:0] idx;
    idx = {MAX_ID_W{1'b0}};
    for (int i = 0; i < MAX_REQS; i++) begin
      idx = idx | (vec[i] ? i[MAX_ID_W-1:0] : {MAX_ID_W{1'b0}});
    end
    return idx;
  endfunction

  // True when at most one bit is set.
  function automatic logic is_onehot0(input logic [MAX_REQS-1:0] vec);
    return (vec & (vec - {{(MAX_REQS-1){1'b0}}, 1'b1})) == {MAX_REQS{1'b0}};
  endfunction

endpackage

// File: rtl/rr_chan_fifo.sv
// Per-channel payload FIFO with a combinational head read and an explicit
// occupancy count that spans 0..DEPTH.
module rr_chan_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;
  assign head_data = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Storage array: written on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally; count tracks push/pop balance.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/rr_req_queue_mux.sv
// Requester-side queue mux: buffers per-channel payloads, raises masked requests
// toward a registered round-robin arbiter and forwards granted heads with an id tag.
module rr_req_queue_mux
  import rr_arb_pkg::*;
#(
  parameter int NUM_REQS = DEF_NUM_REQS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ID_W     = $clog2(NUM_REQS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQS-1:0]        in_valid,
  input  logic [NUM_REQS*DATA_W-1:0] in_data,
  output logic [NUM_REQS-1:0]        in_ready,
  output logic [NUM_REQS-1:0]        reqs,
  input  logic [NUM_REQS-1:0]        grants,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [ID_W-1:0]            out_id,
  output logic                       err_grant
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0]   head_s  [NUM_REQS];
  logic [CNT_W-1:0]    count_s [NUM_REQS];
  logic [NUM_REQS-1:0] full_s;
  logic [NUM_REQS-1:0] empty_s;
  logic [NUM_REQS-1:0] pop_s;
  logic [ID_W-1:0]     gidx_s;
  logic [DATA_W-1:0]   head_sel_s;
  logic                grant_ok_s;
  logic                err_s;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_chan
    rr_chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (in_valid[i] & in_ready[i]),
      .push_data (in_data[i*DATA_W +: DATA_W]),
      .pop       (pop_s[i]),
      .head_data (head_s[i]),
      .count     (count_s[i]),
      .full      (full_s[i]),
      .empty     (empty_s[i])
    );

    assign in_ready[i] = ~full_s[i];
    // Subtracting the live grant keeps a last entry from being requested twice.
    assign reqs[i]     = (count_s[i] > CNT_W'(grants[i]));
  end

  assign gidx_s     = ID_W'(onehot_to_idx(MAX_REQS'(grants)));
  assign head_sel_s = head_s[gidx_s];

  // Grant validation: exactly one grant, and only to a non-empty channel.
  always_comb begin
    grant_ok_s = 1'b0;
    err_s      = 1'b0;
    pop_s      = {NUM_REQS{1'b0}};
    if (grants != {NUM_REQS{1'b0}}) begin
      if (is_onehot0(MAX_REQS'(grants)) && ((grants & empty_s) == {NUM_REQS{1'b0}})) begin
        grant_ok_s = 1'b1;
        pop_s      = grants;
      end else begin
        err_s = 1'b1;
      end
    end else begin
      grant_ok_s = 1'b0;
    end
  end

  // Registered output bus and sticky grant-protocol error.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= {DATA_W{1'b0}};
      out_id    <= {ID_W{1'b0}};
      err_grant <= 1'b0;
    end else begin
      out_valid <= grant_ok_s;
      if (grant_ok_s) begin
        out_data <= head_sel_s;
        out_id   <= gidx_s;
      end
      err_grant <= err_grant | err_s;
    end
  end

endmodule

// File: tb/tb_rr_req_queue_mux.sv
// Directed bench for rr_req_queue_mux: cycle table plus hand sequences for grant
// errors, reset mid-operation and a behavioural round-robin arbiter.
module tb_rr_req_queue_mux;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   in_valid;
  logic [127:0] in_data;
  logic [3:0]   in_ready;
  logic [3:0]   reqs;
  logic [3:0]   grants;
  logic [3:0]   man_g;
  logic [3:0]   arb_g;
  logic         use_arb;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [1:0]   out_id;
  logic         err_grant;
  logic [1:0]   rr_ptr;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]   v;
    logic [127:0] d;
    logic [3:0]   g;
    logic [3:0]   rdy;
    logic [3:0]   rq;
    logic         ov;
    logic [31:0]  od;
    logic [1:0]   oid;
  } vec_t;

  vec_t tbl [$];

  rr_req_queue_mux dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .reqs      (reqs),
    .grants    (grants),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .err_grant (err_grant)
  );

  always #5 clk = ~clk;

  assign grants = use_arb ? arb_g : man_g;

  function automatic logic [3:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [3:0] g;
    g = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (int'(p) + k) % 4;
      if (r[c] && g == 4'b0000) g[c] = 1'b1;
    end
    return g;
  endfunction

  function automatic logic [1:0] rr_next(input logic [3:0] g, input logic [1:0] p);
    logic [1:0] n;
    n = p;
    for (int k = 0; k < 4; k++) begin
      if (g[k]) n = 2'(k + 1);
    end
    return n;
  endfunction

  // Behavioural registered round-robin arbiter.
  always @(posedge clk) begin
    if (reset || !use_arb) begin
      arb_g  <= 4'b0000;
      rr_ptr <= 2'd0;
    end else begin
      arb_g  <= rr_pick(reqs, rr_ptr);
      rr_ptr <= rr_next(rr_pick(reqs, rr_ptr), rr_ptr);
    end
  end

  function automatic logic [127:0] dat(input int ch, input logic [31:0] x);
    logic [127:0] w;
    w = {96'd0, x};
    return w << (ch * 32);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int beats;
  int first_c;
  int last_c;

  initial begin
    reset    = 1'b1;
    in_valid = 4'b0000;
    in_data  = 128'd0;
    man_g    = 4'b0000;
    use_arb  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("reset in_ready", 32'(in_ready), 32'hF);
    chk("reset reqs", 32'(reqs), 32'h0);
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset out_data", out_data, 32'h0);
    chk("reset out_id", 32'(out_id), 32'h0);
    chk("reset err_grant", 32'(err_grant), 32'h0);

    // v, d, g, rdy, rq, ov, od, oid
    tbl.push_back('{4'b0001, dat(0, 32'hA5), 4'b0000, 4'b1111, 4'b0000, 1'b0, 32'h00, 2'd0});
    tbl.push_back('{4'b0000, 128'd0,         4'b0000, 4'b1111, 4'b0001, 1'b0, 32'h00, 2'd0});
    tbl.push_back('{4'b0000, 128'd0,         4'b0001, 4'b1111, 4'b0000, 1'b0, 32'h00, 2'd0});
    tbl.push_back('{4'b0000, 128'd0,         4'b0000, 4'b1111, 4'b0000, 1'b1, 32'hA5, 2'd0});
    tbl.push_back('{4'b0000, 128'd0,         4'b0000, 4'b1111, 4'b0000, 1'b0, 32'hA5, 2'd0});
    tbl.push_back('{4'b0100, dat(2, 32'h20), 4'b0000, 4'b1111, 4'b0000, 1'b0, 32'hA5, 2'd0});
    tbl.push_back('{4'b0100, dat(2, 32'h21), 4'b0000, 4'b1111, 4'b0100, 1'b0, 32'hA5, 2'd0});
    tbl.push_back('{4'b0100, dat(2, 32'h22), 4'b0000, 4'b1111, 4'b0100, 1'b0, 32'hA5, 2'd0});
    tbl.push_back('{4'b0100, dat(2, 32'h23), 4'b0000, 4'b1111, 4'b0100, 1'b0, 32'hA5, 2'd0});
    tbl.push_back('{4'b0100, dat(2, 32'h24), 4'b0000, 4'b1011, 4'b0100, 1'b0, 32'hA5, 2'd0});
    tbl.push_back('{4'b0000, 128'd0,         4'b0100, 4'b1011, 4'b0100, 1'b0, 32'hA5, 2'd0});
    tbl.push_back('{4'b0000, 128'd0,         4'b0100, 4'b1111, 4'b0100, 1'b1, 32'h20, 2'd2});
    tbl.push_back('{4'b0000, 128'd0,         4'b0100, 4'b1111, 4'b0100, 1'b1, 32'h21, 2'd2});
    tbl.push_back('{4'b0000, 128'd0,         4'b0100, 4'b1111, 4'b0000, 1'b1, 32'h22, 2'd2});
    tbl.push_back('{4'b0000, 128'd0,         4'b0000, 4'b1111, 4'b0000, 1'b1, 32'h23, 2'd2});
    tbl.push_back('{4'b0000, 128'd0,         4'b0000, 4'b1111, 4'b0000, 1'b0, 32'h23, 2'd2});
    tbl.push_back('{4'b0010, dat(1, 32'h10), 4'b0000, 4'b1111, 4'b0000, 1'b0, 32'h23, 2'd2});
    tbl.push_back('{4'b0010, dat(1, 32'h11), 4'b0010, 4'b1111, 4'b0000, 1'b0, 32'h23, 2'd2});
    tbl.push_back('{4'b0000, 128'd0,         4'b0000, 4'b1111, 4'b0010, 1'b1, 32'h10, 2'd1});
    tbl.push_back('{4'b0000, 128'd0,         4'b0010, 4'b1111, 4'b0000, 1'b0, 32'h10, 2'd1});
    tbl.push_back('{4'b0000, 128'd0,         4'b0000, 4'b1111, 4'b0000, 1'b1, 32'h11, 2'd1});

    for (int k = 0; k < tbl.size(); k++) begin
      in_valid = tbl[k].v;
      in_data  = tbl[k].d;
      man_g    = tbl[k].g;
      #1;
      chk($sformatf("v%0d in_ready", k), 32'(in_ready), 32'(tbl[k].rdy));
      chk($sformatf("v%0d reqs", k), 32'(reqs), 32'(tbl[k].rq));
      chk($sformatf("v%0d out_valid", k), 32'(out_valid), 32'(tbl[k].ov));
      chk($sformatf("v%0d out_data", k), out_data, tbl[k].od);
      chk($sformatf("v%0d out_id", k), 32'(out_id), 32'(tbl[k].oid));
      chk($sformatf("v%0d err_grant", k), 32'(err_grant), 32'h0);
      tick();
    end
    in_valid = 4'b0000;
    in_data  = 128'd0;
    man_g    = 4'b0000;

    // Grant to an empty channel.
    man_g = 4'b0100;
    tick();
    man_g = 4'b0000;
    #1;
    chk("empty grant out_valid", 32'(out_valid), 32'h0);
    chk("empty grant err", 32'(err_grant), 32'h1);
    tick();
    tick();
    tick();
    chk("err sticky", 32'(err_grant), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("err cleared by reset", 32'(err_grant), 32'h0);

    // Multi-hot grant: no pop, error flagged.
    in_valid = 4'b0011;
    in_data  = dat(0, 32'h30) | dat(1, 32'h31);
    tick();
    in_valid = 4'b0000;
    man_g    = 4'b0011;
    tick();
    man_g = 4'b0000;
    #1;
    chk("multi grant out_valid", 32'(out_valid), 32'h0);
    chk("multi grant err", 32'(err_grant), 32'h1);
    chk("multi grant no pop", 32'(reqs), 32'h3);

    // Reset with three entries queued and a grant presented.
    in_valid = 4'b1000;
    in_data  = dat(3, 32'h33);
    tick();
    in_valid = 4'b0000;
    #1;
    chk("pre-reset reqs", 32'(reqs), 32'hB);
    reset = 1'b1;
    man_g = 4'b0001;
    tick();
    reset = 1'b0;
    man_g = 4'b0000;
    #1;
    chk("mid reset reqs", 32'(reqs), 32'h0);
    chk("mid reset out_valid", 32'(out_valid), 32'h0);
    chk("mid reset in_ready", 32'(in_ready), 32'hF);
    chk("mid reset err", 32'(err_grant), 32'h0);
    chk("mid reset out_data", out_data, 32'h0);
    tick();
    chk("post reset out_valid", 32'(out_valid), 32'h0);

    // One entry per channel served by the round-robin arbiter model.
    in_valid = 4'b1111;
    in_data  = dat(0, 32'h40) | dat(1, 32'h41) | dat(2, 32'h42) | dat(3, 32'h43);
    use_arb  = 1'b1;
    tick();
    in_valid = 4'b0000;
    in_data  = 128'd0;
    beats    = 0;
    first_c  = -1;
    last_c   = -1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (out_valid) begin
        if (beats < 4) begin
          chk($sformatf("arb beat%0d id", beats), 32'(out_id), 32'(beats));
          chk($sformatf("arb beat%0d data", beats), out_data, 32'h40 + 32'(beats));
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        beats++;
      end
      tick();
    end
    chk("arb beat count", 32'(beats), 32'd4);
    chk("arb consecutive", 32'(last_c - first_c), 32'd3);
    chk("arb err_grant", 32'(err_grant), 32'h0);
    chk("arb reqs drained", 32'(reqs), 32'h0);
    use_arb = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
